// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store unit.
// Holds the issue FSM state encoding, the request record and width defaults.
// No logic lives here.
package lsu_pkg;

  localparam int LSU_W         = 32;
  localparam int LSU_MEM_WORDS = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic             we;
    logic [LSU_W-1:0] addr;
    logic [LSU_W-1:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/lsu_fifo.sv
// Purpose: generic DEPTH-entry request FIFO with a combinational head view.
// Latency: a push at edge t is visible at the head (and in count) after edge t.
// Backpressure: full/empty come from the registered count; caller never pushes when full or pops when empty.
module lsu_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 65,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] head_dat,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [DW-1:0] store [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two; push+pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_dat;
  end

  assign head_dat = store[rd_ptr];
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/mem_lsu.sv
// Purpose: in-order load/store unit between a PE and a negedge-write, combinational-read memory.
// Latency: accept at edge t, issue during cycle t+1, response valid after edge t+2; 1 op/cycle sustained.
// Backpressure: req_ready = !full (no bypass); issue stalls while a held response is not taken (HOLD).
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = LSU_MEM_WORDS,
  parameter int W         = LSU_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [W-1:0] req_addr,
  input  logic [W-1:0] req_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_is_ld,
  output logic         rsp_err,
  output logic [W-1:0] rsp_data,
  output logic [W-1:0] ld_addr,
  output logic [W-1:0] st_addr,
  output logic [W-1:0] data_out,
  output logic         write,
  input  logic [W-1:0] data_from_mem,
  output logic         busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = 2*W + 1;

  lsu_state_e     state, state_nxt;
  logic           push, pop, issue;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [DW-1:0]  head_dat;
  logic           head_we, head_oor;
  logic [W-1:0]   head_addr, head_wdata;

  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;

  // Request record packed as {we, addr, wdata}, matching lsu_req_t field order.
  lsu_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (push),
    .push_dat ({req_we, req_addr, req_wdata}),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign head_we    = head_dat[2*W];
  assign head_addr  = head_dat[2*W-1:W];
  assign head_wdata = head_dat[W-1:0];
  assign head_oor   = (head_addr >= W'(MEM_WORDS));

  // The head issues only when the response register is empty or being drained this cycle.
  assign issue = (state == ISSUE) && (!rsp_valid || rsp_ready);
  assign pop   = issue;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: ISSUE stays put while entries remain after this pop (or one arrives).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = ISSUE;
      ISSUE: begin
        if (!issue)                                   state_nxt = HOLD;
        else if ((fifo_count > CW'(1)) || push)       state_nxt = ISSUE;
        else                                          state_nxt = IDLE;
      end
      HOLD:    if (rsp_ready) state_nxt = fifo_empty ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side outputs; write is qualified by the actual issue so a stalled store never commits early.
  always_comb begin
    ld_addr  = '0;
    st_addr  = '0;
    data_out = '0;
    write    = 1'b0;
    if ((state == ISSUE) && !head_oor) begin
      if (head_we) begin
        st_addr  = head_addr;
        data_out = head_wdata;
        write    = issue;
      end else begin
        ld_addr  = head_addr;
      end
    end
  end

  // Response register: load on issue, clear when taken and nothing new issues.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_valid <= 1'b0;
      rsp_is_ld <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else if (issue) begin
      rsp_valid <= 1'b1;
      rsp_is_ld <= !head_we;
      rsp_err   <= head_oor;
      rsp_data  <= head_oor ? '0 : (head_we ? head_wdata : data_from_mem);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign busy = !fifo_empty || rsp_valid;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a 64-word negedge-write memory and a response scoreboard.
// Inputs change 1 time unit after posedge; outputs are sampled 1 unit before posedge.
// Expected responses are computed from a bench-side shadow of memory at push time.
module tb_mem_lsu;
  import lsu_pkg::*;

  localparam int DEPTH     = 4;
  localparam int MEM_WORDS = 64;
  localparam int W         = 32;

  typedef struct packed {
    logic         is_ld;
    logic         err;
    logic [W-1:0] data;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         req_valid, req_ready, req_we;
  logic [W-1:0] req_addr, req_wdata;
  logic         rsp_valid, rsp_ready, rsp_is_ld, rsp_err;
  logic [W-1:0] rsp_data, ld_addr, st_addr, data_out, data_from_mem;
  logic         write, busy;

  always #5 CLK = ~CLK;

  mem_lsu #(.DEPTH(DEPTH), .MEM_WORDS(MEM_WORDS), .W(W)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_is_ld(rsp_is_ld),
    .rsp_err(rsp_err), .rsp_data(rsp_data),
    .ld_addr(ld_addr), .st_addr(st_addr), .data_out(data_out), .write(write),
    .data_from_mem(data_from_mem), .busy(busy)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int wr_cnt = 0;
  int cyc    = 0;
  exp_t exp_q[$];
  int   rsp_cyc[$];

  logic [W-1:0] mem     [MEM_WORDS];
  logic [W-1:0] exp_mem [MEM_WORDS];
  logic [W-1:0] saved   [MEM_WORDS];
  bit           mem_ready = 1'b0;

  function automatic logic [W-1:0] init_word(input int i);
    return 32'hC0DE_0000 + W'(i);
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Memory model: combinational read, write on negedge, contents seeded on the first negedge.
  assign data_from_mem = (ld_addr < W'(MEM_WORDS)) ? mem[ld_addr[5:0]] : '0;
  always @(negedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = init_word(i);
      mem_ready = 1'b1;
    end else if (write && (st_addr < W'(MEM_WORDS))) begin
      mem[st_addr[5:0]] = data_out;
    end
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Response monitor: samples just before each posedge, pops the scoreboard on every handshake.
  always @(negedge CLK) begin
    exp_t e;
    #4;
    if (write) wr_cnt++;
    if (rsp_valid && rsp_ready) begin
      rsp_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_chk++;
        $error("FAIL sb_extra_rsp observed=response data 0x%0h expected=no response", rsp_data);
      end else begin
        e = exp_q.pop_front();
        check("rsp_is_ld", W'(rsp_is_ld), W'(e.is_ld));
        check("rsp_err",   W'(rsp_err),   W'(e.err));
        check("rsp_data",  rsp_data,      e.data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // Offer one request, wait (bounded) for acceptance, then record its expected response.
  task automatic push(input lsu_req_t r);
    int   waited = 0;
    exp_t e;
    req_valid = 1'b1; req_we = r.we; req_addr = r.addr; req_wdata = r.wdata;
    while (!req_ready && waited < 100) begin @(posedge CLK); #1; waited++; end
    if (!req_ready) begin
      check("push_timeout", W'(req_ready), W'(1));
      req_valid = 1'b0;
      return;
    end
    @(posedge CLK); #1;
    e.is_ld = !r.we;
    if (r.addr >= W'(MEM_WORDS)) begin
      e.err = 1'b1; e.data = '0;
    end else if (r.we) begin
      e.err = 1'b0; e.data = r.wdata; exp_mem[r.addr[5:0]] = r.wdata;
    end else begin
      e.err = 1'b0; e.data = exp_mem[r.addr[5:0]];
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin @(posedge CLK); #1; n++; end
    check(tag, W'(busy), W'(0));
  endtask

  initial begin
    int wr0, a0;
    bit seen;
    for (int i = 0; i < MEM_WORDS; i++) exp_mem[i] = init_word(i);
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

    // Asynchronous reset: outputs clear before any clock edge.
    #1 RST = 1'b1;
    #1;
    check("rst_rsp_valid", W'(rsp_valid), W'(0));
    check("rst_write",     W'(write),     W'(0));
    check("rst_busy",      W'(busy),      W'(0));
    check("rst_rsp_data",  rsp_data,      W'(0));
    check("rst_rsp_err",   W'(rsp_err),   W'(0));
    check("rst_rsp_is_ld", W'(rsp_is_ld), W'(0));
    tick(2);
    RST = 1'b0;
    check("req_ready_after_rst", W'(req_ready), W'(1));

    // Store then load to the same word.
    wr0 = wr_cnt;
    push('{we: 1'b1, addr: 32'd5, wdata: 32'h0000_00AA});
    push('{we: 1'b0, addr: 32'd5, wdata: 32'h0});
    req_valid = 1'b0;
    wait_idle("st_ld_idle");
    check("st_ld_write_cycles", W'(wr_cnt - wr0), W'(1));
    check("st_ld_mem5", mem[5], 32'h0000_00AA);

    // Fill the FIFO behind a stalled response.
    rsp_ready = 1'b0;
    wr0 = wr_cnt;
    for (int k = 0; k < 5; k++) push('{we: 1'b1, addr: W'(10 + k), wdata: 32'h5000_0000 + W'(k)});
    check("fill_req_ready", W'(req_ready), W'(0));
    check("fill_one_issue", W'(wr_cnt - wr0), W'(1));
    req_valid = 1'b0;
    tick(3);
    check("hold_one_issue", W'(wr_cnt - wr0), W'(1));
    check("hold_rsp_valid", W'(rsp_valid), W'(1));
    check("hold_count", W'(dut.fifo_count), W'(DEPTH));
    rsp_ready = 1'b1;
    wait_idle("fill_idle");
    check("fill_all_written", W'(wr_cnt - wr0), W'(5));
    for (int k = 0; k < 5; k++) check("fill_mem", mem[10 + k], 32'h5000_0000 + W'(k));

    // Out-of-range load and store.
    wr0 = wr_cnt;
    push('{we: 1'b0, addr: 32'd64,  wdata: 32'h0});
    push('{we: 1'b1, addr: 32'd100, wdata: 32'h0000_1234});
    req_valid = 1'b0;
    wait_idle("oor_idle");
    check("oor_no_write", W'(wr_cnt - wr0), W'(0));
    check("oor_mem36", mem[36], exp_mem[36]);
    check("oor_mem0",  mem[0],  exp_mem[0]);

    // Back-to-back loads: first response two cycles after first accept, then one per cycle.
    rsp_cyc.delete();
    a0 = 0;
    for (int k = 0; k < 8; k++) begin
      push('{we: 1'b0, addr: W'(k), wdata: 32'h0});
      if (k == 0) a0 = cyc;
    end
    req_valid = 1'b0;
    wait_idle("b2b_idle");
    check("b2b_rsp_count", W'(rsp_cyc.size()), W'(8));
    for (int k = 0; k < 8 && k < rsp_cyc.size(); k++) check("b2b_rsp_cycle", W'(rsp_cyc[k]), W'(a0 + 2 + k));

    // Reset with a held response drained, a store issuing and three loads queued.
    saved = exp_mem;
    rsp_ready = 1'b0;
    push('{we: 1'b0, addr: 32'd1,  wdata: 32'h0});
    push('{we: 1'b1, addr: 32'd20, wdata: 32'hDEAD_BEEF});
    for (int k = 0; k < 3; k++) push('{we: 1'b0, addr: W'(21 + k), wdata: 32'h0});
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick(1);
    check("rst_mid_write_before", W'(write), W'(1));
    check("rst_mid_st_addr", st_addr, W'(20));
    RST = 1'b1;
    #1;
    check("rst_mid_write_drop", W'(write), W'(0));
    check("rst_mid_busy", W'(busy), W'(0));
    check("rst_mid_rsp_valid", W'(rsp_valid), W'(0));
    exp_q.delete();
    exp_mem = saved;
    tick(2);
    RST = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin tick(1); seen |= rsp_valid; end
    check("rst_mid_no_rsp", W'(seen), W'(0));
    check("rst_mid_mem20", mem[20], exp_mem[20]);
    check("rst_mid_busy_after", W'(busy), W'(0));

    // Steady push+pop at count DEPTH-1 across several pointer wraps.
    rsp_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 4) rsp_ready = 1'b1;
      push('{we: 1'b0, addr: W'(30 + i), wdata: 32'h0});
      if (i >= 5) check("wrap_count", W'(dut.fifo_count), W'(DEPTH - 1));
    end
    req_valid = 1'b0;
    wait_idle("wrap_idle");

    tick(2);
    check("sb_drained", W'(exp_q.size()), W'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
